// File: rtl/pcileech_com_pkg.sv
// Shared word-format constants and types for the host-to-FPGA receive path.
package pcileech_com_pkg;

    localparam logic [7:0] COM_MAGIC = 8'h77;

    typedef enum logic [1:0] {
        COM_TLP = 2'd0,
        COM_CFG = 2'd1,
        COM_LB  = 2'd2,
        COM_CMD = 2'd3
    } com_type_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } com_tlp_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FRAME   = 2'd1,
        DISCARD = 2'd2
    } tlp_fsm_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pcileech_sync_fifo_fwft.sv
// Small first-word-fall-through FIFO; a read on a full queue frees the slot for a same-cycle write.
module pcileech_sync_fifo_fwft #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_rd;
    logic             w_wr;

    assign w_rd = i_rd_en && (r_count != '0);
    assign w_wr = i_wr_en && ((r_count != FULL_CNT) || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Data is forced to zero while empty so stale storage never shows on the outputs.
    assign o_valid   = (r_count != '0);
    assign o_rd_data = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count   = r_count;

endmodule

// File: rtl/pcileech_com_rx_demux.sv
// Validates host words, routes them to TLP/CFG/LOOPBACK/CMD queues and reassembles TLP framing.
module pcileech_com_rx_demux
    import pcileech_com_pkg::*;
#(
    parameter int TLP_DEPTH  = 64,
    parameter int CTL_DEPTH  = 8,
    parameter int MAX_TLP_DW = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic [31:0] tlp_data,
    output logic        tlp_last,
    output logic        tlp_err,
    output logic        tlp_valid,
    input  logic        tlp_ready,
    output logic [63:0] cfg_data,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic [63:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [63:0] lb_data,
    output logic        lb_valid,
    input  logic        lb_ready,
    output logic [15:0] cnt_badmagic,
    output logic [15:0] cnt_drop,
    output logic [15:0] cnt_abort
);

    localparam int TAW = $clog2(TLP_DEPTH);
    localparam int CAW = $clog2(CTL_DEPTH);
    localparam int DW  = $clog2(MAX_TLP_DW + 1);
    localparam logic [TAW:0]  TLP_DATA_LIMIT = (TAW+1)'(TLP_DEPTH - 1);
    localparam logic [CAW:0]  CTL_FULL       = (CAW+1)'(CTL_DEPTH);
    localparam logic [DW-1:0] DW_MAX         = DW'(MAX_TLP_DW);

    logic [63:0]   r_in_data;
    logic          r_in_valid;
    tlp_fsm_t      r_state;
    tlp_fsm_t      w_state_next;
    logic [DW-1:0] r_dwcnt;
    logic [DW-1:0] w_dwcnt_next;
    logic [DW-1:0] w_dwcnt_inc;
    logic [15:0]   r_cnt_badmagic;
    logic [15:0]   r_cnt_drop;
    logic [15:0]   r_cnt_abort;

    logic          w_magic_ok;
    logic          w_good;
    logic          w_last;
    logic          w_tlp_hit;
    logic          w_tlp_space;
    logic          w_tlp_wr;
    logic          w_tlp_rd;
    logic          w_tlp_drop;
    logic          w_tlp_abort;
    logic          w_tlp_valid;
    logic [TAW:0]  w_tlp_count;
    com_tlp_t      w_tlp_wdata;
    com_tlp_t      w_tlp_rdata;

    logic [2:0]    w_ctl_hit;
    logic [2:0]    w_ctl_wr;
    logic [2:0]    w_ctl_rd;
    logic [2:0]    w_ctl_valid;
    logic [2:0]    w_ctl_ready;
    logic          w_ctl_drop;
    logic [63:0]   w_ctl_data  [3];
    logic [CAW:0]  w_ctl_count [3];

    assign w_magic_ok  = (r_in_data[7:0] == COM_MAGIC);
    assign w_good      = r_in_valid && w_magic_ok;
    assign w_last      = r_in_data[10];
    assign w_tlp_hit   = w_good && (r_in_data[9:8] == COM_TLP);
    assign w_tlp_space = (w_tlp_count < TLP_DATA_LIMIT);
    assign w_dwcnt_inc = r_dwcnt + 1'b1;

    // Control queue gi carries word type gi+1: CFG, LOOPBACK, CMD.
    assign w_ctl_ready = {cmd_ready, lb_ready, cfg_ready};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ctl
            assign w_ctl_hit[gi] = w_good && (r_in_data[9:8] == 2'(gi + 1));
            assign w_ctl_rd[gi]  = w_ctl_valid[gi] && w_ctl_ready[gi];
            assign w_ctl_wr[gi]  = w_ctl_hit[gi] && ((w_ctl_count[gi] != CTL_FULL) || w_ctl_rd[gi]);

            pcileech_sync_fifo_fwft #(
                .WIDTH (64),
                .DEPTH (CTL_DEPTH)
            ) u_ctl_fifo (
                .clk       (clk),
                .rst       (rst),
                .i_wr_en   (w_ctl_wr[gi]),
                .i_wr_data (r_in_data),
                .i_rd_en   (w_ctl_rd[gi]),
                .o_rd_data (w_ctl_data[gi]),
                .o_valid   (w_ctl_valid[gi]),
                .o_count   (w_ctl_count[gi])
            );
        end
    endgenerate

    assign w_ctl_drop = |(w_ctl_hit & ~w_ctl_wr);

    always_comb begin
        w_state_next = r_state;
        w_dwcnt_next = r_dwcnt;
        w_tlp_wr     = 1'b0;
        w_tlp_wdata  = '0;
        w_tlp_drop   = 1'b0;
        w_tlp_abort  = 1'b0;
        if (w_tlp_hit) begin
            case (r_state)
                IDLE: begin
                    if (w_tlp_space) begin
                        w_tlp_wr         = 1'b1;
                        w_tlp_wdata.data = r_in_data[63:32];
                        w_tlp_wdata.last = w_last;
                        if (!w_last) begin
                            w_state_next = FRAME;
                            w_dwcnt_next = DW'(1);
                        end
                    end else begin
                        w_tlp_drop = 1'b1;
                        if (!w_last) w_state_next = DISCARD;
                    end
                end
                FRAME: begin
                    if (w_tlp_space) begin
                        w_tlp_wr         = 1'b1;
                        w_tlp_wdata.data = r_in_data[63:32];
                        w_tlp_wdata.last = w_last;
                        w_dwcnt_next     = w_dwcnt_inc;
                        if (w_last) begin
                            w_state_next = IDLE;
                        end else if (w_dwcnt_inc == DW_MAX) begin
                            w_tlp_wdata.last = 1'b1;
                            w_tlp_wdata.err  = 1'b1;
                            w_tlp_abort      = 1'b1;
                            w_state_next     = DISCARD;
                        end
                    end else begin
                        // The reserved slot always holds the terminator, so the frame closes cleanly.
                        w_tlp_wr         = 1'b1;
                        w_tlp_wdata.last = 1'b1;
                        w_tlp_wdata.err  = 1'b1;
                        w_tlp_abort      = 1'b1;
                        w_tlp_drop       = 1'b1;
                        w_state_next     = w_last ? IDLE : DISCARD;
                    end
                end
                default: begin
                    w_tlp_drop = 1'b1;
                    if (w_last) w_state_next = IDLE;
                end
            endcase
        end
    end

    pcileech_sync_fifo_fwft #(
        .WIDTH ($bits(com_tlp_t)),
        .DEPTH (TLP_DEPTH)
    ) u_tlp_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_tlp_wr),
        .i_wr_data (w_tlp_wdata),
        .i_rd_en   (w_tlp_rd),
        .o_rd_data (w_tlp_rdata),
        .o_valid   (w_tlp_valid),
        .o_count   (w_tlp_count)
    );

    assign w_tlp_rd = w_tlp_valid && tlp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_data      <= '0;
            r_in_valid     <= 1'b0;
            r_state        <= IDLE;
            r_dwcnt        <= '0;
            r_cnt_badmagic <= '0;
            r_cnt_drop     <= '0;
            r_cnt_abort    <= '0;
        end else begin
            r_in_data  <= in_data;
            r_in_valid <= in_valid;
            r_state    <= w_state_next;
            r_dwcnt    <= w_dwcnt_next;
            if (r_in_valid && !w_magic_ok) r_cnt_badmagic <= sat_inc(r_cnt_badmagic);
            if (w_tlp_drop || w_ctl_drop)  r_cnt_drop     <= sat_inc(r_cnt_drop);
            if (w_tlp_abort)               r_cnt_abort    <= sat_inc(r_cnt_abort);
        end
    end

    assign tlp_valid    = w_tlp_valid;
    assign tlp_data     = w_tlp_rdata.data;
    assign tlp_last     = w_tlp_rdata.last;
    assign tlp_err      = w_tlp_rdata.err;
    assign cfg_data     = w_ctl_data[0];
    assign cfg_valid    = w_ctl_valid[0];
    assign lb_data      = w_ctl_data[1];
    assign lb_valid     = w_ctl_valid[1];
    assign cmd_data     = w_ctl_data[2];
    assign cmd_valid    = w_ctl_valid[2];
    assign cnt_badmagic = r_cnt_badmagic;
    assign cnt_drop     = r_cnt_drop;
    assign cnt_abort    = r_cnt_abort;

endmodule

// File: doc/pcileech_com_rx_demux.md
Name: pcileech_com_rx_demux

Overview:
- Consumes the 64-bit host-to-FPGA word stream produced by the communication core (dout/valid, clk domain, no backpressure).
- Validates each word, classifies it by type, and routes it into one of four small output queues: TLP dword stream, CFG, CMD, LOOPBACK.
- Reassembles TLP framing, handles overflow without corrupting frames, and keeps saturating error counters for status readout.

Parameters:
- TLP_DEPTH, 64: TLP queue depth in entries; power of 2, at least 4.
- CTL_DEPTH, 8: depth of each of the CFG, CMD and LOOPBACK queues; power of 2, at least 2.
- MAX_TLP_DW, 1024: maximum dwords per TLP frame before a forced abort.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high
- in_data  in  64  host word
- in_valid  in  1  word strobe; no ready signal exists
- tlp_data  out  32  TLP dword
- tlp_last  out  1  last dword of frame
- tlp_err  out  1  aborted-frame marker; valid only when tlp_last=1
- tlp_valid  out  1
- tlp_ready  in  1
- cfg_data  out  64;  cfg_valid  out  1;  cfg_ready  in  1
- cmd_data  out  64;  cmd_valid  out  1;  cmd_ready  in  1
- lb_data  out  64;  lb_valid  out  1;  lb_ready  in  1
- cnt_badmagic  out  16  words dropped for bad magic, saturating
- cnt_drop  out  16  words dropped on overflow or discard, saturating
- cnt_abort  out  16  TLP frames aborted, saturating

Behaviour:
- Word format:
  - [7:0] = magic 8'h77.
  - [9:8] = type: 0 TLP, 1 CFG, 2 LOOPBACK, 3 CMD.
  - [10] = TLP last.
  - [63:32] = payload dword for TLP.
  - CFG, CMD and LOOPBACK forward the full 64 bits.
  - Example: 64'h00000003_80182377 is a CMD word.
- Input is registered once, so a word is written into its queue 2 cycles after in_valid.
- All outputs are first-word-fall-through: data is valid while valid=1, and transfers on valid&ready.
- Input bad magic: drop the word and increment cnt_badmagic. The TLP framer state is unaffected.
- CFG, CMD or LOOPBACK word arriving with its queue full: drop the word and increment cnt_drop.
- TLP framer FSM, states IDLE, FRAME, DISCARD:
  - The TLP queue accepts a data word only while count < TLP_DEPTH-1. The last slot is reserved for an abort terminator.
  - IDLE, TLP word, space available: write {data, last, err=0}. If last=0, go to FRAME with dwcnt=1.
  - FRAME, TLP word, space available: write it and increment dwcnt. If last=1, go to IDLE.
  - FRAME, dwcnt reaches MAX_TLP_DW without last: write the word with last=1, err=1; increment cnt_abort; go to DISCARD.
  - FRAME, no space: write the terminator {32'h0, last=1, err=1} into the reserved slot; increment cnt_abort and cnt_drop; go to DISCARD. If the incoming word had last=1, go to IDLE instead.
  - IDLE, no space: drop the word and increment cnt_drop. If last=0, go to DISCARD.
  - DISCARD: drop every TLP word and increment cnt_drop. On last=1, go to IDLE.
  - Non-TLP words are processed in every state and do not change framer state.
- Simultaneous write and read on a full queue: the read frees the slot first, so the write is accepted (count unchanged).
- Counters saturate at 16'hFFFF and never wrap.
- Reset (also mid-frame): all queues empty, all valid outputs 0, all data outputs 0, FSM to IDLE, all counters 0. Partially queued frames are flushed. The input register is cleared, so a word arriving during rst is lost.

Decomposition:
- Package pcileech_com_pkg:
  - COM_MAGIC = 8'h77.
  - typedef enum logic[1:0] com_type_t {COM_TLP, COM_CFG, COM_LB, COM_CMD}.
  - typedef struct packed com_tlp_t {data[31:0], last, err}.
  - typedef enum tlp_fsm_t {IDLE, FRAME, DISCARD}.
- Sub-module pcileech_sync_fifo_fwft, parameterised WIDTH and DEPTH, with count output.
  - Instantiated 4 times: WIDTH 34 for TLP, 64 for the others.

Test Plan:
- Single 64'h00000003_80182377 with cmd_ready=1 -> cmd_valid=1 with that data 2 cycles later; no other valid; all counters 0.
- TLP frame of 3 words (payloads 0xA, 0xB, 0xC; last on the 3rd) with tlp_ready=1 -> 3 dwords, last only on 0xC, err=0.
- Word 64'h0000_0000_0000_0176 (bad magic) -> no output, cnt_badmagic=1.
- tlp_ready=0, TLP_DEPTH=8, 10-word frame -> 7 data words, then terminator with last=1/err=1; cnt_abort=1, cnt_drop=3; the next frame passes cleanly once drained.
- cfg_ready=0, CTL_DEPTH=8, 10 CFG words interleaved with TLP words -> 8 CFG queued, cnt_drop=2, TLP stream intact.
- rst asserted in FRAME after 2 words -> all valids 0 the cycle after rst; the following frame delivers from IDLE with err=0.
